// File: rtl/iq_pkg.sv
// Shared constants for the unified issue queue: FU classes, sizing and
// broadcast-port ordering.
package iq_pkg;

   localparam int IQ_DEPTH  = 16;
   localparam int PRF_WIDTH = 6;

   localparam logic [1:0] FU_ALU = 2'd0;
   localparam logic [1:0] FU_MUL = 2'd1;
   localparam logic [1:0] FU_LS  = 2'd2;

   // Broadcast and grant port order: alu0, alu1, mul, ls.
   localparam int BC_ALU0 = 0;
   localparam int BC_ALU1 = 1;
   localparam int BC_MUL  = 2;
   localparam int BC_LS   = 3;
   localparam int BC_NUM  = 4;

endpackage

// File: rtl/iq_free_finder.sv
// Lowest-index free slot finder: priority encoder over the inverted valid
// vector, with a flag that is low only when every entry is occupied.
module iq_free_finder #(
   parameter int DEPTH = 16,
   parameter int IDX_W = 4
) (
   input  logic [DEPTH-1:0] valid,
   output logic [IDX_W-1:0] idx,
   output logic             found
);

   always_comb begin
      idx   = '0;
      found = 1'b0;
      // Scan downward so the lowest free index is the last one written.
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (!valid[i]) begin
            idx   = IDX_W'(i);
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/iq_entry_array.sv
// Issue-queue entry storage: allocates one dispatched uop per cycle, tracks
// per-source readiness, and deallocates on up to four issue grants.
module iq_entry_array
   import iq_pkg::*;
#(
   parameter int DEPTH      = iq_pkg::IQ_DEPTH,
   parameter int PRF_WIDTH  = iq_pkg::PRF_WIDTH,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          flush,
   input  logic                          disp_vld,
   input  logic [PRF_WIDTH-1:0]          disp_prd,
   input  logic [PRF_WIDTH-1:0]          disp_prs1,
   input  logic [PRF_WIDTH-1:0]          disp_prs2,
   input  logic                          disp_prs1_rdy,
   input  logic                          disp_prs2_rdy,
   input  logic [1:0]                    disp_fu,
   output logic                          disp_rdy,
   input  logic [3:0]                    bcast_vld,
   input  logic [4*PRF_WIDTH-1:0]        bcast_tag,
   input  logic [DEPTH-1:0]              prs1_wake,
   input  logic [DEPTH-1:0]              prs2_wake,
   input  logic                          grant_alu0,
   input  logic                          grant_alu1,
   input  logic                          grant_mul,
   input  logic                          grant_ls,
   input  logic [ADDR_WIDTH-1:0]         addr_alu0,
   input  logic [ADDR_WIDTH-1:0]         addr_alu1,
   input  logic [ADDR_WIDTH-1:0]         addr_mul,
   input  logic [ADDR_WIDTH-1:0]         addr_ls,
   output logic [DEPTH*PRF_WIDTH-1:0]    ciq_prd,
   output logic [DEPTH*PRF_WIDTH-1:0]    ciq_prs1,
   output logic [DEPTH*PRF_WIDTH-1:0]    ciq_prs2,
   output logic [DEPTH-1:0]              req_alu,
   output logic [DEPTH-1:0]              req_mul,
   output logic [DEPTH-1:0]              req_ls,
   output logic [ADDR_WIDTH-1:0]         count,
   output logic                          full
);

   localparam int IDX_W = $clog2(DEPTH);

   logic [DEPTH-1:0]      valid_q, rdy1_q, rdy2_q;
   logic [1:0]            fu_q   [DEPTH];
   logic [PRF_WIDTH-1:0]  prd_q  [DEPTH];
   logic [PRF_WIDTH-1:0]  prs1_q [DEPTH];
   logic [PRF_WIDTH-1:0]  prs2_q [DEPTH];
   logic [ADDR_WIDTH-1:0] count_q;

   logic [IDX_W-1:0]      free_idx;
   logic                  free_found;
   logic                  alloc;
   logic [DEPTH-1:0]      alloc_mask;
   logic                  rdy1_in, rdy2_in;
   logic [3:0]            gnt_v;
   logic [ADDR_WIDTH-1:0] gnt_a [BC_NUM];
   logic [DEPTH-1:0]      dealloc;
   logic [ADDR_WIDTH-1:0] n_dealloc;
   logic [ADDR_WIDTH-1:0] count_next;

   iq_free_finder #(
      .DEPTH (DEPTH),
      .IDX_W (IDX_W)
   ) u_free_finder (
      .valid (valid_q),
      .idx   (free_idx),
      .found (free_found)
   );

   assign full     = (count_q == ADDR_WIDTH'(DEPTH));
   assign disp_rdy = ~full;
   assign count    = count_q;
   assign alloc    = disp_vld & ~full & free_found;

   always_comb begin
      alloc_mask = '0;
      if (alloc) alloc_mask[free_idx] = 1'b1;
   end

   // Same-cycle broadcast bypass so a dispatching uop never misses a wake-up.
   always_comb begin
      rdy1_in = disp_prs1_rdy | (disp_prs1 == '0);
      rdy2_in = disp_prs2_rdy | (disp_prs2 == '0);
      for (int k = 0; k < BC_NUM; k++) begin
         if (bcast_vld[k] && (bcast_tag[k*PRF_WIDTH +: PRF_WIDTH] == disp_prs1)) rdy1_in = 1'b1;
         if (bcast_vld[k] && (bcast_tag[k*PRF_WIDTH +: PRF_WIDTH] == disp_prs2)) rdy2_in = 1'b1;
      end
   end

   assign gnt_v = {grant_ls, grant_mul, grant_alu1, grant_alu0};

   always_comb begin
      gnt_a[BC_ALU0] = addr_alu0;
      gnt_a[BC_ALU1] = addr_alu1;
      gnt_a[BC_MUL]  = addr_mul;
      gnt_a[BC_LS]   = addr_ls;
   end

   // Out-of-range addresses are dropped; duplicates collapse onto one bit.
   always_comb begin
      dealloc = '0;
      for (int k = 0; k < BC_NUM; k++) begin
         if (gnt_v[k] && (gnt_a[k][ADDR_WIDTH-1:IDX_W] == '0))
            dealloc[gnt_a[k][IDX_W-1:0]] = 1'b1;
      end
      dealloc = dealloc & valid_q;
   end

   always_comb begin
      n_dealloc = '0;
      for (int i = 0; i < DEPTH; i++) n_dealloc = n_dealloc + ADDR_WIDTH'(dealloc[i]);
      count_next = count_q + ADDR_WIDTH'(alloc) - n_dealloc;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
         rdy1_q  <= '0;
         rdy2_q  <= '0;
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            fu_q[i]   <= '0;
            prd_q[i]  <= '0;
            prs1_q[i] <= '0;
            prs2_q[i] <= '0;
         end
      end else if (flush) begin
         valid_q <= '0;
         count_q <= '0;
      end else begin
         valid_q <= (valid_q & ~dealloc) | alloc_mask;
         rdy1_q  <= ((rdy1_q | (prs1_wake & valid_q)) & ~dealloc & ~alloc_mask)
                    | (alloc_mask & {DEPTH{rdy1_in}});
         rdy2_q  <= ((rdy2_q | (prs2_wake & valid_q)) & ~dealloc & ~alloc_mask)
                    | (alloc_mask & {DEPTH{rdy2_in}});
         count_q <= count_next;
         if (alloc) begin
            fu_q[free_idx]   <= disp_fu;
            prd_q[free_idx]  <= disp_prd;
            prs1_q[free_idx] <= disp_prs1;
            prs2_q[free_idx] <= disp_prs2;
         end
      end
   end

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         ciq_prd [i*PRF_WIDTH +: PRF_WIDTH] = prd_q[i];
         ciq_prs1[i*PRF_WIDTH +: PRF_WIDTH] = prs1_q[i];
         ciq_prs2[i*PRF_WIDTH +: PRF_WIDTH] = prs2_q[i];
         req_alu[i] = valid_q[i] & rdy1_q[i] & rdy2_q[i] & (fu_q[i] == FU_ALU);
         req_mul[i] = valid_q[i] & rdy1_q[i] & rdy2_q[i] & (fu_q[i] == FU_MUL);
         req_ls[i]  = valid_q[i] & rdy1_q[i] & rdy2_q[i] & (fu_q[i] == FU_LS);
      end
   end

endmodule

// File: doc/iq_entry_array.md
Name: iq_entry_array

Overview:
- 16-entry unified issue-queue storage for the RV64 out-of-order backend.
- Accepts one dispatched uop per cycle and holds its destination and source physical tags plus per-source ready bits.
- Sets ready bits from the per-entry wake-up vectors and deallocates entries on the select stage's grants.
- Exports the tag arrays that the wake-up comparator reads, and per-FU-class request vectors consumed by the select arbiters.

Parameters:
- DEPTH, 16, number of entries (power of two).
- PRF_WIDTH, 6, physical register tag width.
- ADDR_WIDTH, 5, width of grant entry addresses; bit 4 is always 0 for DEPTH=16.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  pipeline flush; empties the queue.
- disp_vld  in  1  dispatch request.
- disp_prd  in  PRF_WIDTH  destination tag.
- disp_prs1  in  PRF_WIDTH  source-1 tag.
- disp_prs2  in  PRF_WIDTH  source-2 tag.
- disp_prs1_rdy  in  1  source-1 ready per busy table.
- disp_prs2_rdy  in  1  source-2 ready per busy table.
- disp_fu  in  2  FU class: 0=ALU, 1=MUL, 2=LS; 3 is illegal.
- disp_rdy  out  1  queue can accept (= ~full).
- bcast_vld  in  4  tag broadcast valid: alu0, alu1, mul, ls.
- bcast_tag  in  4*PRF_WIDTH  broadcast tags, same order as bcast_vld.
- prs1_wake  in  DEPTH  per-entry source-1 match from the wake-up block.
- prs2_wake  in  DEPTH  per-entry source-2 match from the wake-up block.
- grant_alu0, grant_alu1, grant_mul, grant_ls  in  1 each  issue grants.
- addr_alu0, addr_alu1, addr_mul, addr_ls  in  ADDR_WIDTH each  granted entry index.
- ciq_prd  out  DEPTH*PRF_WIDTH  stored destination tags, entry i at [i*PRF_WIDTH +: PRF_WIDTH].
- ciq_prs1  out  DEPTH*PRF_WIDTH  stored source-1 tags, same packing.
- ciq_prs2  out  DEPTH*PRF_WIDTH  stored source-2 tags, same packing.
- req_alu  out  DEPTH  entry valid, both sources ready, fu==ALU.
- req_mul  out  DEPTH  entry valid, both sources ready, fu==MUL.
- req_ls  out  DEPTH  entry valid, both sources ready, fu==LS.
- count  out  ADDR_WIDTH  number of valid entries, 0..16.
- full  out  1  count==DEPTH.

Behaviour:
- Reset (async, rst_n=0):
  - all valid, rdy1, rdy2, fu and tag fields clear to 0.
  - count=0, full=0, disp_rdy=1, all req vectors 0.
- Per-entry state: valid, prd, prs1, prs2, rdy1, rdy2, fu. All updates happen at the clk rising edge.
- Allocation:
  - Target slot = lowest-index entry with valid=0, computed from the current-cycle valid vector.
  - Write occurs when disp_vld & ~full. disp_vld while full is ignored and no state changes.
- Dispatch readiness, source 1 (source 2 identical):
  - rdy1 written as disp_prs1_rdy | (disp_prs1==0) | OR over k of (bcast_vld[k] & bcast_tag[k]==disp_prs1).
  - This bypass covers a tag broadcast in the same cycle as dispatch.
- Wake-up:
  - For each valid entry, rdy1 <= rdy1 | prs1_wake[i]; rdy2 <= rdy2 | prs2_wake[i].
  - Wake vectors are masked by valid, so invalid entries never change.
  - Ready bits are sticky until deallocation.
- Deallocation:
  - For each asserted grant, valid[addr] <= 0.
  - Up to 4 deallocations per cycle.
  - Two grants to the same address are tolerated: one deallocation, count decremented once.
  - An address bit 4 set, or a grant to an invalid entry, is ignored.
- Simultaneous events:
  - A slot freed this cycle is not reallocated until the next cycle, because allocation uses the pre-edge valid vector.
  - Dispatch and grant never target the same entry in the same cycle.
  - Wake-up and grant on the same entry: grant wins, entry becomes invalid.
- count: count_next = count + alloc − popcount(distinct deallocated valid entries). Never underflows or overflows.
- flush:
  - Clears all valid bits next edge; count=0.
  - Overrides dispatch and grants in the same cycle.
  - Tag fields need not clear.
- req vectors, full and disp_rdy are combinational from registered state only (no dispatch-to-request path).
- Issue latency: an entry dispatched fully ready at edge N appears in req_* after edge N. A wake at edge N makes the entry requestable in cycle N+1.
- Tag outputs are registered fields driven directly.

Decomposition:
- Shared package iq_pkg:
  - FU class constants FU_ALU=2'd0, FU_MUL=2'd1, FU_LS=2'd2.
  - IQ_DEPTH, PRF_WIDTH.
  - Broadcast index constants BC_ALU0..BC_LS.
- One natural sub-module: iq_free_finder, a lowest-zero priority encoder over the valid vector producing the slot index and a found flag.

Test Plan:
- Reset then dispatch prd=10, prs1=3 rdy, prs2=4 not rdy, fu=ALU -> entry0 valid, ciq_prd[0]=10, req_alu=0, count=1; then prs2_wake[0]=1 -> next cycle req_alu[0]=1.
- Dispatch 16 uops with disp_vld held -> full=1 and disp_rdy=0 after the 16th; a 17th disp_vld changes nothing, count stays 16.
- Queue full, grant_alu0 addr 3 and grant_ls addr 7 same cycle -> count=14; next dispatch lands in slot 3, the following one in slot 7.
- Dispatch prs1=9 not rdy while bcast_vld[2]=1, bcast_tag[2]=9 -> entry stored with rdy1=1; disp_prs2=0 -> rdy2=1.
- Entries 0..5 valid, flush=1 together with disp_vld and grant_mul -> next cycle count=0, all req vectors 0, no entry valid.
- Assert rst_n low mid-operation with 8 valid entries -> outputs go to reset values immediately, without a clock edge.
